// File: rtl/mlp_pkg.sv
// Shared types and helpers for the time-multiplexed perceptron layer.
// The accumulator width leaves headroom for NUM_IN full-scale products plus a bias.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_e;

  localparam logic ACT_STEP = 1'b0;
  localparam logic ACT_RELU = 1'b1;

  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned num_in);
    return 2 * data_w + $clog2(num_in) + 1;
  endfunction

endpackage

// File: rtl/mac_act_unit.sv
// Combinational multiply-accumulate step plus step/ReLU activation of the new sum.
// The activated value only matters on the last product of a neuron.
module mac_act_unit
  import mlp_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACC_W     = 19,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic                     mode,
  output logic signed [ACC_W-1:0]  next_acc,
  output logic        [DATA_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] MaxPos = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    shifted;

  // Operands are widened up front so the low 2*DATA_W product bits are exact.
  assign prod     = $signed({{DATA_W{x[DATA_W-1]}}, x}) * $signed({{DATA_W{w[DATA_W-1]}}, w});
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign next_acc = acc + prod_ext;
  assign shifted  = next_acc >>> FRAC_BITS;

  always_comb begin
    result = '0;
    if (mode == ACT_STEP) begin
      result[0] = ~next_acc[ACC_W-1] & (|next_acc);
    end else if (!next_acc[ACC_W-1]) begin
      if (shifted > MaxPos) begin
        result = MaxPos[DATA_W-1:0];
      end else begin
        result = shifted[DATA_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mlp_layer_seq.sv
// Fully connected perceptron layer sharing one MAC across all neuron/input products.
// Weights and bias are read live; only the input vector and mode are latched.
module mlp_layer_seq
  import mlp_pkg::*;
#(
  parameter int unsigned NUM_IN      = 3,
  parameter int unsigned NUM_NEURONS = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FRAC_BITS   = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_IN*DATA_W-1:0]             in_data,
  input  logic                                 act_mode,
  input  logic [NUM_NEURONS*NUM_IN*DATA_W-1:0] weights,
  input  logic [NUM_NEURONS*DATA_W-1:0]        bias,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_NEURONS*DATA_W-1:0]        out_data,
  output logic                                 busy
);

  localparam int unsigned ACC_W = acc_width(DATA_W, NUM_IN);
  localparam int unsigned IW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IW-1:0] ILast = IW'(NUM_IN - 1);
  localparam logic [NW-1:0] NLast = NW'(NUM_NEURONS - 1);

  state_e                   state_q, state_d;
  logic [NUM_IN*DATA_W-1:0] x_q, x_d;
  logic                     mode_q, mode_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IW-1:0]            i_q, i_d;
  logic [NW-1:0]            n_q, n_d;
  logic [DATA_W-1:0]        y_q [NUM_NEURONS];
  logic [DATA_W-1:0]        y_d [NUM_NEURONS];

  logic signed [DATA_W-1:0] x_arr [NUM_IN];
  logic signed [DATA_W-1:0] w_arr [NUM_NEURONS][NUM_IN];
  logic signed [DATA_W-1:0] b_arr [NUM_NEURONS];
  logic signed [ACC_W-1:0]  next_acc;
  logic [DATA_W-1:0]        act_result;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_x
    assign x_arr[gi] = x_q[gi*DATA_W +: DATA_W];
  end

  for (genvar gn = 0; gn < NUM_NEURONS; gn++) begin : g_n
    assign b_arr[gn]                   = bias[gn*DATA_W +: DATA_W];
    assign out_data[gn*DATA_W +: DATA_W] = y_q[gn];
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_w
      assign w_arr[gn][gi] = weights[(gn*NUM_IN+gi)*DATA_W +: DATA_W];
    end
  end

  mac_act_unit #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .acc     (acc_q),
    .x       (x_arr[i_q]),
    .w       (w_arr[n_q][i_q]),
    .mode    (mode_q),
    .next_acc(next_acc),
    .result  (act_result)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    i_d       = i_q;
    n_d       = n_q;
    y_d       = y_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          mode_d  = act_mode;
          acc_d   = sext(b_arr[0]);
          i_d     = '0;
          n_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (i_q == ILast) begin
          y_d[n_q] = act_result;
          i_d      = '0;
          if (n_q == NLast) begin
            acc_d   = '0;
            state_d = DONE;
          end else begin
            n_d   = n_q + NW'(1);
            acc_d = sext(b_arr[n_d]);
          end
        end else begin
          acc_d = next_acc;
          i_d   = i_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      i_q     <= '0;
      n_q     <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      n_q     <= n_d;
      y_q     <= y_d;
    end
  end

endmodule
